// File: rtl/stim_player_pkg.sv
// rtl/stim_player_pkg.sv - shared types and constants for the stimulus vector player
package stim_player_pkg;

  // Playback sequencer states
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_PAUSE,
    ST_DONE
  } state_e;

  // MISR feedback taps for the output signature
  localparam logic [15:0] SIG_POLY = 16'hB400;

  // Saturation value of the 16-bit wrap counter
  localparam logic [15:0] CNT_SAT = 16'hFFFF;

endpackage

// File: rtl/stim_vec_ram.sv
// rtl/stim_vec_ram.sv - 1W1R synchronous read-first vector table
module stim_vec_ram #(
  parameter int DEPTH  = 1011,
  parameter int VEC_W  = 3,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clock,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [VEC_W-1:0]  wr_data,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic [VEC_W-1:0]  rd_data
);

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  logic [VEC_W-1:0] mem_q [DEPTH];
  logic             wr_ok;

  // Addresses past the last entry are not backed by storage and are dropped
  assign wr_ok = wr_en && ({1'b0, wr_addr} < DEPTH_L);

  // Write and read on the same edge; the read returns the pre-write contents
  always_ff @(posedge clock) begin
    if (wr_ok) begin
      mem_q[wr_addr] <= wr_data;
    end
    if (rd_en) begin
      rd_data <= mem_q[rd_addr];
    end
  end

endmodule

// File: rtl/stim_vector_player.sv
// rtl/stim_vector_player.sv - vector table sequencer with run/pause/stop, loop and optional MISR (STIM_PLAYER_SIG_EN)
module stim_vector_player #(
  parameter int VEC_W  = 3,
  parameter int DEPTH  = 1011,
  parameter int ADDR_W = $clog2(DEPTH),
  parameter int CNT_W  = 32,
  parameter int OBS_W  = 4,
  parameter int SIG_W  = 16
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [VEC_W-1:0]  wr_data,
  input  logic              start,
  input  logic              stop,
  input  logic              pause,
  input  logic              loop_mode,
  input  logic [ADDR_W:0]   length,
  input  logic [OBS_W-1:0]  obs_in,
  output logic [VEC_W-1:0]  vec_out,
  output logic              vec_valid,
  output logic              busy,
  output logic              done,
  output logic [CNT_W-1:0]  issued_cnt,
  output logic [15:0]       wrap_cnt,
  output logic [SIG_W-1:0]  sig_out
);

  import stim_player_pkg::*;

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  state_e            state_q;
  logic [ADDR_W:0]   len_q;
  logic              loop_q;
  logic [ADDR_W-1:0] rd_ptr_q;
  logic              rd_vld_q;   // table read data is waiting to be issued
  logic              rd_last_q;  // that pending data is the last entry of a pass
  logic              rd_end_q;   // one-shot pass has read its last entry
  logic [VEC_W-1:0]  vec_q;
  logic              vec_valid_q;
  logic              busy_q;
  logic              done_q;
  logic [CNT_W-1:0]  issued_q;
  logic [15:0]       wrap_q;

  logic              busy_st;
  logic              start_ok;
  logic              adv;
  logic              rd_fire;
  logic              ptr_last;
  logic [ADDR_W:0]   len_d;
  logic [VEC_W-1:0]  ram_rd_data;

  assign busy_st  = (state_q == ST_RUN) || (state_q == ST_PAUSE);
  assign start_ok = start && !busy_st;
  // One playback step: issue any pending vector and fetch the next entry
  assign adv      = busy_st && !stop && !pause;
  assign rd_fire  = adv && !rd_end_q;
  assign ptr_last = ({1'b0, rd_ptr_q} == (len_q - (ADDR_W+1)'(1)));
  assign len_d    = ((length == '0) || (length > DEPTH_L)) ? DEPTH_L : length;

  stim_vec_ram #(
    .DEPTH  (DEPTH),
    .VEC_W  (VEC_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clock   (clock),
    .wr_en   (wr_en),
    .wr_addr (wr_addr),
    .wr_data (wr_data),
    .rd_en   (rd_fire),
    .rd_addr (rd_ptr_q),
    .rd_data (ram_rd_data)
  );

  // Playback FSM with read pipeline, issue stage and counters
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      len_q       <= DEPTH_L;
      loop_q      <= 1'b0;
      rd_ptr_q    <= '0;
      rd_vld_q    <= 1'b0;
      rd_last_q   <= 1'b0;
      rd_end_q    <= 1'b0;
      vec_q       <= '0;
      vec_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      issued_q    <= '0;
      wrap_q      <= '0;
    end else if (stop) begin
      state_q     <= ST_IDLE;
      rd_vld_q    <= 1'b0;
      vec_q       <= '0;
      vec_valid_q <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
    end else if (start_ok) begin
      state_q     <= ST_RUN;
      len_q       <= len_d;
      loop_q      <= loop_mode;
      rd_ptr_q    <= '0;
      rd_vld_q    <= 1'b0;
      rd_last_q   <= 1'b0;
      rd_end_q    <= 1'b0;
      vec_valid_q <= 1'b0;
      busy_q      <= 1'b1;
      done_q      <= 1'b0;
      issued_q    <= '0;
      wrap_q      <= '0;
    end else if (busy_st && pause) begin
      // Freeze: pending read data stays in the RAM output register
      state_q     <= ST_PAUSE;
      vec_valid_q <= 1'b0;
    end else if (adv) begin
      state_q <= ST_RUN;
      if (rd_vld_q) begin
        vec_q       <= ram_rd_data;
        vec_valid_q <= 1'b1;
        if (!(&issued_q)) begin
          issued_q <= issued_q + CNT_W'(1);
        end
        if (rd_last_q && loop_q && (wrap_q != CNT_SAT)) begin
          wrap_q <= wrap_q + 16'd1;
        end
      end else begin
        vec_valid_q <= 1'b0;
      end
      rd_vld_q <= rd_fire;
      if (!rd_end_q) begin
        rd_last_q <= ptr_last;
        if (ptr_last) begin
          rd_ptr_q <= '0;
          rd_end_q <= !loop_q;
        end else begin
          rd_ptr_q <= rd_ptr_q + ADDR_W'(1);
        end
      end
      // Nothing pending and nothing left to read: the one-shot pass is over
      if (!rd_vld_q && rd_end_q) begin
        state_q <= ST_DONE;
        busy_q  <= 1'b0;
        done_q  <= 1'b1;
      end
    end
  end

  assign vec_out    = vec_q;
  assign vec_valid  = vec_valid_q;
  assign busy       = busy_q;
  assign done       = done_q;
  assign issued_cnt = issued_q;
  assign wrap_cnt   = wrap_q;

`ifdef STIM_PLAYER_SIG_EN
  logic [SIG_W-1:0] sig_q;

  // MISR compaction of DUT outputs on every cycle carrying a fresh vector
  always_ff @(posedge clock) begin
    if (reset) begin
      sig_q <= '0;
    end else if (stop) begin
      sig_q <= sig_q;
    end else if (start_ok) begin
      sig_q <= '0;
    end else if (vec_valid_q) begin
      sig_q <= {sig_q[SIG_W-2:0], ^(sig_q & SIG_W'(SIG_POLY))} ^ SIG_W'(obs_in);
    end
  end

  assign sig_out = sig_q;
`else
  logic unused_obs;

  assign unused_obs = ^obs_in;
  assign sig_out    = '0;
`endif

endmodule

// File: tb/tb_stim_vector_player.sv
// tb/tb_stim_vector_player.sv - self-checking bench for stim_vector_player
module tb_stim_vector_player;

  localparam int DEPTH  = 1011;
  localparam int ADDR_W = $clog2(DEPTH);

  logic              clock;
  logic              reset;
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [2:0]        wr_data;
  logic              start;
  logic              stop;
  logic              pause;
  logic              loop_mode;
  logic [ADDR_W:0]   length;
  logic [3:0]        obs_in;
  logic [2:0]        vec_out;
  logic              vec_valid;
  logic              busy;
  logic              done;
  logic [31:0]       issued_cnt;
  logic [15:0]       wrap_cnt;
  logic [15:0]       sig_out;

  int n_checks = 0;
  int n_fail   = 0;
  logic [2:0] tmem [DEPTH];

  stim_vector_player dut (
    .clock      (clock),
    .reset      (reset),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .start      (start),
    .stop       (stop),
    .pause      (pause),
    .loop_mode  (loop_mode),
    .length     (length),
    .obs_in     (obs_in),
    .vec_out    (vec_out),
    .vec_valid  (vec_valid),
    .busy       (busy),
    .done       (done),
    .issued_cnt (issued_cnt),
    .wrap_cnt   (wrap_cnt),
    .sig_out    (sig_out)
  );

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Signature after n valid cycles with a constant observed value, starting from zero
  function automatic logic [15:0] misr_ref(input int n, input logic [3:0] obs);
    logic [15:0] s;
    s = 16'h0;
    for (int i = 0; i < n; i++) begin
      s = ((s << 1) | 16'(^(s & 16'hB400))) ^ {12'h0, obs};
    end
    return s;
  endfunction

  task automatic tb_write(input int addr, input logic [2:0] data);
    wr_en   = 1'b1;
    wr_addr = ADDR_W'(addr);
    wr_data = data;
    @(negedge clock);
    wr_en   = 1'b0;
    if (addr < DEPTH) tmem[addr] = data;
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_busy"}, busy, 0);
    check_eq({tag, "_valid"}, vec_valid, 0);
    check_eq({tag, "_vec"}, vec_out, 0);
    check_eq({tag, "_done"}, done, 0);
  endtask

  task automatic do_stop();
    stop = 1'b1;
    @(negedge clock);
    stop = 1'b0;
    check_idle("stop");
  endtask

  // Start a pass and follow n_issue vectors; with pause_pct > 0 pause is toggled at random
  task automatic play(input int len_req, input bit lp, input int n_issue, input int pause_pct);
    int len_eff;
    int k;
    int guard;
    bit p;
    len_eff = (len_req == 0 || len_req > DEPTH) ? DEPTH : len_req;
    length    = (ADDR_W+1)'(len_req);
    loop_mode = lp;
    start     = 1'b1;
    @(negedge clock);
    start = 1'b0;
    check_eq("busy_after_start", busy, 1);
    @(negedge clock);
    check_eq("latency_no_valid", vec_valid, 0);
    @(negedge clock);
    check_eq("latency_first_valid", vec_valid, 1);
    check_eq("first_vec", vec_out, tmem[0]);
    k = 1;
    guard = 0;
    while (k < n_issue && guard < 20000) begin
      p = (pause_pct > 0) && ($urandom_range(99) < pause_pct);
      pause = p;
      @(negedge clock);
      guard++;
      check_eq("valid_vs_pause", vec_valid, !p);
      if (vec_valid) begin
        check_eq("vec_order", vec_out, tmem[k % len_eff]);
        k++;
      end
    end
    pause = 1'b0;
    check_eq("play_budget", guard < 20000, 1);
    check_eq("issued_cnt", issued_cnt, n_issue);
    if (lp) begin
      check_eq("wrap_cnt", wrap_cnt, n_issue / len_eff);
    end else begin
      check_eq("done_before_end", done, 0);
      @(negedge clock);
      check_eq("done", done, 1);
      check_eq("done_busy", busy, 0);
      check_eq("done_valid", vec_valid, 0);
      check_eq("done_vec_hold", vec_out, tmem[len_eff-1]);
      check_eq("done_wrap", wrap_cnt, 0);
`ifdef STIM_PLAYER_SIG_EN
      check_eq("sig", sig_out, misr_ref(len_eff, obs_in));
`else
      check_eq("sig_off", sig_out, 0);
`endif
    end
  endtask

  int  r_len;
  bit  r_lp;
  int  r_n;

  initial begin
    reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
    start = 1'b0; stop = 1'b0; pause = 1'b0; loop_mode = 1'b0;
    length = '0; obs_in = 4'hA;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    check_idle("reset");
    check_eq("reset_issued", issued_cnt, 0);
    check_eq("reset_wrap", wrap_cnt, 0);
    check_eq("reset_sig", sig_out, 0);

    // T2: five-entry one-shot
    for (int i = 0; i < 5; i++) tb_write(i, 3'(i + 1));
    play(5, 1'b0, 5, 0);

    // T3: looping, 12 issues, no bubble at the wrap, then stop holds counters
    play(5, 1'b1, 12, 0);
    do_stop();
    check_eq("stop_issued_hold", issued_cnt, 12);
    check_eq("stop_wrap_hold", wrap_cnt, 2);

    // T4: pause for three cycles after the second vector
    length = 11'd5; loop_mode = 1'b0; start = 1'b1;
    @(negedge clock); start = 1'b0;
    @(negedge clock);
    @(negedge clock); check_eq("t4_v1", vec_out, tmem[0]);
    @(negedge clock); check_eq("t4_v2", vec_out, tmem[1]);
    pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i == 2) begin
        @(negedge clock);
        pause = 1'b0;
      end else begin
        @(negedge clock);
      end
      check_eq("t4_paused_valid", vec_valid, 0);
      check_eq("t4_paused_hold", vec_out, tmem[1]);
      check_eq("t4_paused_busy", busy, 1);
    end
    for (int i = 2; i < 5; i++) begin
      @(negedge clock);
      check_eq("t4_resume_valid", vec_valid, 1);
      check_eq("t4_resume_vec", vec_out, tmem[i]);
    end
    @(negedge clock);
    check_eq("t4_done", done, 1);
    check_eq("t4_issued", issued_cnt, 5);

    // T5: stop and start together mid-run, then start on the next cycle
    play(5, 1'b1, 7, 0);
    stop = 1'b1; start = 1'b1;
    @(negedge clock);
    stop = 1'b0; start = 1'b0;
    check_idle("t5");
    check_eq("t5_issued_hold", issued_cnt, 7);
    check_eq("t5_wrap_hold", wrap_cnt, 1);
    play(5, 1'b0, 5, 0);

    // T1: reset mid-run, table contents survive
    play(5, 1'b1, 3, 0);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check_idle("t1");
    check_eq("t1_issued", issued_cnt, 0);
    check_eq("t1_wrap", wrap_cnt, 0);
    check_eq("t1_sig", sig_out, 0);
    play(5, 1'b0, 5, 0);

    // Random table, full-depth passes and random short runs with random pauses
    for (int i = 0; i < DEPTH; i++) tb_write(i, 3'($urandom_range(7)));
    tb_write(DEPTH + 3, 3'h7);
    play(0, 1'b0, DEPTH, 20);
    play(2000, 1'b0, DEPTH, 0);
    for (int r = 0; r < 8; r++) begin
      r_len = $urandom_range(1, 30);
      r_lp  = 1'($urandom_range(1));
      r_n   = r_lp ? $urandom_range(1, 3 * r_len) : r_len;
      play(r_len, r_lp, r_n, 25);
      if (r_lp) do_stop();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
